register_file_16x32: RTL and testbench

- Architectural register file of the single-cycle ARM-subset datapath: R0-R14 storage, R15 supplied externally as PC+8.
- Sits directly upstream of the 16-to-1 read multiplexers. Three read ports (RD1, RD2, debug) each select one of 16 sources.
- One general write port from the writeback stage, plus a dedicated link write (R14) for BL.
- Drives the ALU operand path and the store-data path.

---
 rtl/register_file_16x32_pkg.sv | 12 +
 rtl/register_file_16x32_if.sv | 29 ++
 rtl/register_file_16x32_mux16.sv | 12 +
 rtl/register_file_16x32_write_decoder_4to16.sv | 16 +
 rtl/register_file_16x32.sv | 73 +++++++
 tb/tb_register_file_16x32.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/register_file_16x32_pkg.sv
// Shared constants for the architectural register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_file_16x32_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_LINK_REG   = 14;
    localparam int RF_PC_REG     = 15;
    localparam int RF_NUM_REGS   = 16;
    localparam int RF_ADDR_W     = 4;

endpackage

// File: rtl/register_file_16x32_if.sv
// Read/write bus of the register file: three read ports, general and link write ports.
// Latency: reads combinational, writes commit on the rising clock edge.
// Backpressure: none; every write presented with its enable is taken.
interface register_file_16x32_if;
    import register_file_16x32_pkg::*;

    logic [RF_ADDR_W-1:0]     a1;
    logic [RF_ADDR_W-1:0]     a2;
    logic [RF_ADDR_W-1:0]     a_dbg;
    logic [RF_ADDR_W-1:0]     a3;
    logic [RF_DATA_WIDTH-1:0] wd3;
    logic                     we3;
    logic                     link_we;
    logic [RF_DATA_WIDTH-1:0] link_wd;
    logic [RF_DATA_WIDTH-1:0] r15_in;
    logic [RF_DATA_WIDTH-1:0] rd1;
    logic [RF_DATA_WIDTH-1:0] rd2;
    logic [RF_DATA_WIDTH-1:0] rd_dbg;

    modport master (
        output a1, a2, a_dbg, a3, wd3, we3, link_we, link_wd, r15_in,
        input  rd1, rd2, rd_dbg
    );

    modport slave (
        input  a1, a2, a_dbg, a3, wd3, we3, link_we, link_wd, r15_in,
        output rd1, rd2, rd_dbg
    );
endinterface

// File: rtl/register_file_16x32_mux16.sv
// 16-to-1 read multiplexer, one word wide.
// Latency: combinational.
// Backpressure: none.
module mux16to1 #(
    parameter int W = 32
) (
    input  logic [3:0]   sel,
    input  logic [W-1:0] din [16],
    output logic [W-1:0] dout
);
    assign dout = din[sel];
endmodule

// File: rtl/register_file_16x32_write_decoder_4to16.sv
// 4-to-16 one-hot write-enable decoder; all zeros when en is low.
// Latency: combinational.
// Backpressure: none.
module write_decoder_4to16 (
    input  logic [3:0]  addr,
    input  logic        en,
    output logic [15:0] onehot
);
    // Single bit set at addr when enabled, never more than one
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/register_file_16x32.sv
// Architectural register file: R0-R14 in flops, R15 reads return r15_in (PC+8).
// Latency: reads combinational (no forwarding), writes visible after the rising edge.
// Backpressure: none; a3==15 writes are dropped, link write beats a general write to R14.
module register_file_16x32
    import register_file_16x32_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int LINK_REG   = RF_LINK_REG,
    parameter int PC_REG     = RF_PC_REG
) (
    input  logic                  clk,
    input  logic                  reset_n,
    register_file_16x32_if.slave  bus
);
    logic [DATA_WIDTH-1:0] regs [RF_NUM_REGS-1];
    logic [DATA_WIDTH-1:0] src  [RF_NUM_REGS];
    logic [RF_NUM_REGS-1:0] wr_oh;
    logic                   wr_en;
    logic                   unused_pc_sel;

    // PC writes belong to the PC register, so they never reach the decoder
    assign wr_en = bus.we3 && (bus.a3 != RF_ADDR_W'(PC_REG));

    write_decoder_4to16 u_dec (
        .addr   (bus.a3),
        .en     (wr_en),
        .onehot (wr_oh)
    );

    // Bit 15 is always zero because of the enable gating above
    assign unused_pc_sel = wr_oh[RF_NUM_REGS-1];

    // Register storage: async clear, link port takes priority on R14
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RF_NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RF_NUM_REGS - 1; i++) begin
                if (bus.link_we && (i == LINK_REG)) begin
                    regs[i] <= bus.link_wd;
                end else if (wr_oh[i]) begin
                    regs[i] <= bus.wd3;
                end
            end
        end
    end

    // Read sources: stored registers plus the external PC+8 as R15
    for (genvar g = 0; g < RF_NUM_REGS - 1; g++) begin : g_src
        assign src[g] = regs[g];
    end
    assign src[RF_NUM_REGS-1] = bus.r15_in;

    mux16to1 #(.W(DATA_WIDTH)) u_rd1 (
        .sel  (bus.a1),
        .din  (src),
        .dout (bus.rd1)
    );

    mux16to1 #(.W(DATA_WIDTH)) u_rd2 (
        .sel  (bus.a2),
        .din  (src),
        .dout (bus.rd2)
    );

    mux16to1 #(.W(DATA_WIDTH)) u_rd_dbg (
        .sel  (bus.a_dbg),
        .din  (src),
        .dout (bus.rd_dbg)
    );
endmodule

// File: tb/tb_register_file_16x32.sv
module tb_register_file_16x32;
    logic clk;
    logic reset_n;

    register_file_16x32_if bus ();

    register_file_16x32 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we3;
        logic [3:0]  a3;
        logic [31:0] wd3;
        logic        link_we;
        logic [31:0] link_wd;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a_dbg;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_dbg;
    } vec_t;

    localparam int NVEC = 7;
    localparam logic [31:0] PC8 = 32'h0000_0108;

    vec_t        vecs [NVEC];
    logic [31:0] exp_final [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_writes();
        bus.we3     = 1'b0;
        bus.a3      = 4'd0;
        bus.wd3     = '0;
        bus.link_we = 1'b0;
        bus.link_wd = '0;
    endtask

    initial begin
        // write vectors: each is one clock edge, reads checked just after it
        vecs[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 32'h0,         4'd3,  4'd4,  4'd15, 32'hDEAD_BEEF, 32'h0,         PC8};
        vecs[1] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 32'h0,         4'd3,  4'd0,  4'd15, 32'hDEAD_BEEF, 32'h0,         PC8};
        vecs[2] = '{1'b1, 4'd14, 32'hAAAA_AAAA, 1'b1, 32'h0000_0204, 4'd14, 4'd3,  4'd15, 32'h0000_0204, 32'hDEAD_BEEF, PC8};
        vecs[3] = '{1'b1, 4'd2,  32'h7,         1'b1, 32'h9,         4'd2,  4'd14, 4'd3,  32'h7,         32'h9,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 4'd3,  32'h0,         1'b0, 32'h0,         4'd3,  4'd2,  4'd14, 32'hDEAD_BEEF, 32'h7,         32'h9};
        vecs[5] = '{1'b1, 4'd0,  32'h11,        1'b1, 32'h300,       4'd0,  4'd14, 4'd1,  32'h11,        32'h300,       32'h0};
        vecs[6] = '{1'b1, 4'd5,  32'hCAFE_0005, 1'b0, 32'h0,         4'd5,  4'd3,  4'd15, 32'hCAFE_0005, 32'hDEAD_BEEF, PC8};

        for (int i = 0; i < 16; i++) exp_final[i] = 32'h0;
        exp_final[0]  = 32'h11;
        exp_final[2]  = 32'h7;
        exp_final[3]  = 32'hDEAD_BEEF;
        exp_final[5]  = 32'h1234_5678;
        exp_final[14] = 32'h300;
        exp_final[15] = PC8;

        // reset state
        reset_n    = 1'b0;
        bus.r15_in = PC8;
        bus.a1     = 4'd0;
        bus.a2     = 4'd0;
        bus.a_dbg  = 4'd0;
        idle_writes();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.a1 = 4'(a);
            #1;
            check($sformatf("reset_rd1_r%0d", a), bus.rd1, (a == 15) ? PC8 : 32'h0);
        end

        // table-driven writes and reads
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            bus.we3     = vecs[v].we3;
            bus.a3      = vecs[v].a3;
            bus.wd3     = vecs[v].wd3;
            bus.link_we = vecs[v].link_we;
            bus.link_wd = vecs[v].link_wd;
            bus.a1      = vecs[v].a1;
            bus.a2      = vecs[v].a2;
            bus.a_dbg   = vecs[v].a_dbg;
            @(posedge clk);
            #1;
            idle_writes();
            #1;
            check($sformatf("vec%0d_rd1", v), bus.rd1, vecs[v].exp_rd1);
            check($sformatf("vec%0d_rd2", v), bus.rd2, vecs[v].exp_rd2);
            check($sformatf("vec%0d_dbg", v), bus.rd_dbg, vecs[v].exp_dbg);
        end

        // no forwarding: old value before the edge, new value right after
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.a3  = 4'd5;
        bus.wd3 = 32'h1234_5678;
        bus.a2  = 4'd5;
        #1;
        check("nofwd_before_edge", bus.rd2, 32'hCAFE_0005);
        @(posedge clk);
        #1;
        check("nofwd_after_edge", bus.rd2, 32'h1234_5678);
        idle_writes();

        // R15 write is dropped; sweep all registers on the debug port
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.a3  = 4'd15;
        bus.wd3 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        idle_writes();
        bus.r15_in = 32'h0000_0200;
        exp_final[15] = 32'h0000_0200;
        for (int a = 0; a < 16; a++) begin
            bus.a_dbg = 4'(a);
            #1;
            check($sformatf("r15prot_dbg_r%0d", a), bus.rd_dbg, exp_final[a]);
        end

        // dual write, then async reset mid-cycle with no clock edge
        @(negedge clk);
        bus.we3     = 1'b1;
        bus.a3      = 4'd2;
        bus.wd3     = 32'h7;
        bus.link_we = 1'b1;
        bus.link_wd = 32'h9;
        bus.a1      = 4'd2;
        bus.a2      = 4'd14;
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        check("dual_r2", bus.rd1, 32'h7);
        check("dual_r14", bus.rd2, 32'h9);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd1", bus.rd1, 32'h0);
        check("async_rst_rd2", bus.rd2, 32'h0);

        // writes held through edges while reset is low are blocked
        bus.we3     = 1'b1;
        bus.a3      = 4'd6;
        bus.wd3     = 32'h66;
        bus.link_we = 1'b1;
        bus.link_wd = 32'h77;
        bus.a1      = 4'd6;
        bus.a2      = 4'd14;
        @(posedge clk);
        #1;
        check("rst_block_r6", bus.rd1, 32'h0);
        check("rst_block_r14", bus.rd2, 32'h0);

        // first edge after release accepts the write
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_pre_edge_r6", bus.rd1, 32'h0);
        @(posedge clk);
        #1;
        check("release_first_edge_r6", bus.rd1, 32'h66);
        check("release_first_edge_r14", bus.rd2, 32'h77);
        idle_writes();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
